// File: rtl/prog_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_seq_if
// Brief    : Control/status bundle between decoder/ALU (master) and prog_seq.
// Revision : 1.0
// ============================================================================
interface prog_seq_if #(
    parameter int L     = 10,
    parameter int NPROG = 3
);
    localparam int PW = (NPROG > 1) ? $clog2(NPROG) : 1;

    logic          start;
    logic          halt;
    logic          branch_abs;
    logic          branch_rel;
    logic          cond;
    logic          alu_flag;
    logic          call;
    logic          ret;
    logic [L-1:0]  target;
    logic [L-1:0]  prog_ctr;
    logic [PW-1:0] prog_num;
    logic          running;
    logic          done;
    logic          stack_err;

    modport master (
        output start, halt, branch_abs, branch_rel, cond, alu_flag, call, ret, target,
        input  prog_ctr, prog_num, running, done, stack_err
    );

    modport slave (
        input  start, halt, branch_abs, branch_rel, cond, alu_flag, call, ret, target,
        output prog_ctr, prog_num, running, done, stack_err
    );
endinterface
`default_nettype wire

// File: rtl/prog_seq.sv
`default_nettype none
// ============================================================================
// Module   : prog_seq
// Brief    : Multi-program sequencer with branch/call/return; the return-address
//            stack is present only when PROG_SEQ_RAS_EN is defined.
// Revision : 1.0
// ============================================================================
module prog_seq #(
    parameter int L           = 10,
    parameter int NPROG       = 3,
    parameter int PROG_STRIDE = 256,
    parameter int DEPTH       = 4
) (
    input  logic      clk,
    input  logic      rst,
    prog_seq_if.slave bus
);
    localparam int            PW        = (NPROG > 1) ? $clog2(NPROG) : 1;
    localparam logic [PW-1:0] LAST_PROG = PW'(NPROG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [L-1:0]  pc_q, pc_d;
    logic [PW-1:0] num_q, num_d;
    logic [L-1:0]  w_pc_inc;
    logic          w_taken;

    function automatic logic [L-1:0] base_of(input logic [PW-1:0] k);
        logic [31:0] prod;
        prod = 32'(k) * 32'(PROG_STRIDE);
        return prod[L-1:0];
    endfunction

    assign w_pc_inc = pc_q + L'(1);
    assign w_taken  = !bus.cond || bus.alu_flag;

`ifdef PROG_SEQ_RAS_EN
    localparam int           AW     = $clog2(DEPTH);
    localparam logic [AW:0]  SP_ONE = (AW + 1)'(1);
    localparam logic [AW:0]  FULL   = (AW + 1)'(DEPTH);

    logic [L-1:0] stk_q [DEPTH];
    logic [AW:0]  sp_q;
    logic [AW:0]  w_sp_m1;
    logic         err_q;
    logic         w_push, w_pop, w_clear, w_err_set;

    assign w_sp_m1 = sp_q - SP_ONE;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        num_d   = num_q;
`ifdef PROG_SEQ_RAS_EN
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_clear   = 1'b0;
        w_err_set = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    pc_d    = base_of(num_q);
                end
            end
            S_HALT: begin
                if (bus.start && (num_q != LAST_PROG)) begin
                    state_d = S_RUN;
                    num_d   = num_q + PW'(1);
                    pc_d    = base_of(num_q + PW'(1));
`ifdef PROG_SEQ_RAS_EN
                    w_clear = 1'b1;
`endif
                end
            end
            S_RUN: begin
                pc_d = w_pc_inc;
                if (bus.halt) begin
                    state_d = S_HALT;
                    pc_d    = pc_q;
                end
`ifdef PROG_SEQ_RAS_EN
                else if (bus.ret) begin
                    if (sp_q != '0) begin
                        pc_d  = stk_q[w_sp_m1[AW-1:0]];
                        w_pop = 1'b1;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
                else if (bus.call) begin
                    // A full stack still takes the jump; only the push is lost.
                    if (w_taken) begin
                        pc_d = bus.target;
                        if (sp_q == FULL) w_err_set = 1'b1;
                        else              w_push    = 1'b1;
                    end
                end
`else
                else if (bus.call) begin
                    if (w_taken) pc_d = bus.target;
                end
`endif
                else if (bus.branch_abs) begin
                    if (w_taken) pc_d = bus.target;
                end
                else if (bus.branch_rel) begin
                    if (w_taken) pc_d = pc_q + bus.target;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            num_q   <= num_d;
        end
    end

`ifdef PROG_SEQ_RAS_EN
    always_ff @(posedge clk) begin
        if (w_push) stk_q[sp_q[AW-1:0]] <= w_pc_inc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (w_err_set) err_q <= 1'b1;
            if (w_clear)     sp_q <= '0;
            else if (w_push) sp_q <= sp_q + SP_ONE;
            else if (w_pop)  sp_q <= w_sp_m1;
        end
    end

    assign bus.stack_err = err_q;
`else
    logic w_unused;
    assign w_unused      = bus.ret;
    assign bus.stack_err = 1'b0;
`endif

    assign bus.prog_ctr = pc_q;
    assign bus.prog_num = num_q;
    assign bus.running  = (state_q == S_RUN);
    assign bus.done     = (state_q == S_HALT);
endmodule
`default_nettype wire

// File: tb/tb_prog_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_seq
// Brief    : Directed plus randomized bench for prog_seq against a queue-based
//            reference model; follows PROG_SEQ_RAS_EN like the design.
// Revision : 1.0
// ============================================================================
module tb_prog_seq;
    localparam int L           = 10;
    localparam int NPROG       = 3;
    localparam int PROG_STRIDE = 256;
    localparam int DEPTH       = 4;
    localparam int MOD         = 1 << L;
`ifdef PROG_SEQ_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_seq_if #(.L(L), .NPROG(NPROG)) ifc ();

    prog_seq #(
        .L(L), .NPROG(NPROG), .PROG_STRIDE(PROG_STRIDE), .DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: 0=IDLE 1=RUN 2=HALT, return addresses in a queue.
    int m_state = 0;
    int m_pc    = 0;
    int m_num   = 0;
    bit m_err   = 1'b0;
    int m_stk[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int base_of(input int k);
        return (k * PROG_STRIDE) % MOD;
    endfunction

    task automatic model_step();
        int off;
        bit taken;
        taken = !ifc.cond || ifc.alu_flag;
        if (rst) begin
            m_state = 0; m_pc = 0; m_num = 0; m_err = 1'b0;
            m_stk.delete();
        end else if (m_state == 0) begin
            if (ifc.start) begin m_state = 1; m_pc = base_of(m_num); end
        end else if (m_state == 2) begin
            if (ifc.start && m_num < NPROG - 1) begin
                m_num++;
                m_pc = base_of(m_num);
                m_stk.delete();
                m_state = 1;
            end
        end else begin
            if (ifc.halt) m_state = 2;
            else if (RAS && ifc.ret) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_err = 1'b1; m_pc = (m_pc + 1) % MOD; end
            end else if (ifc.call) begin
                if (taken) begin
                    if (RAS) begin
                        if (m_stk.size() == DEPTH) m_err = 1'b1;
                        else m_stk.push_back((m_pc + 1) % MOD);
                    end
                    m_pc = int'(ifc.target);
                end else m_pc = (m_pc + 1) % MOD;
            end else if (ifc.branch_abs) begin
                m_pc = taken ? int'(ifc.target) : (m_pc + 1) % MOD;
            end else if (ifc.branch_rel) begin
                off = int'(ifc.target);
                if (off >= MOD / 2) off -= MOD;
                m_pc = taken ? (((m_pc + off) % MOD) + MOD) % MOD : (m_pc + 1) % MOD;
            end else m_pc = (m_pc + 1) % MOD;
        end
    endtask

    task automatic clear_inputs();
        rst = 1'b0;
        ifc.start = 1'b0; ifc.halt = 1'b0; ifc.branch_abs = 1'b0; ifc.branch_rel = 1'b0;
        ifc.cond = 1'b0; ifc.alu_flag = 1'b0; ifc.call = 1'b0; ifc.ret = 1'b0;
        ifc.target = '0;
    endtask

    // One clock: the DUT and the model consume the same inputs, then outputs are compared.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("pc",        ifc.prog_ctr,  m_pc);
        check("prog_num",  ifc.prog_num,  m_num);
        check("running",   ifc.running,   32'(m_state == 1));
        check("done",      ifc.done,      32'(m_state == 2));
        check("stack_err", ifc.stack_err, 32'(m_err));
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        check("reset_pc", ifc.prog_ctr, 0);
        check("reset_running", ifc.running, 0);

        rst = 1'b1; ifc.start = 1'b1; tick();
        check("reset_beats_start", ifc.running, 0);

        ifc.start = 1'b1; tick();
        repeat (5) tick();
        check("seq_pc5", ifc.prog_ctr, 5);
        check("seq_running", ifc.running, 1);
        check("seq_num", ifc.prog_num, 0);

        repeat (2) tick();
        ifc.branch_rel = 1'b1; ifc.target = 10'h3FC; tick();
        check("rel_back4", ifc.prog_ctr, 3);
        ifc.branch_abs = 1'b1; ifc.cond = 1'b1; ifc.alu_flag = 1'b0; ifc.target = 10'd100; tick();
        check("abs_not_taken", ifc.prog_ctr, 4);

        repeat (16) tick();
        ifc.call = 1'b1; ifc.target = 10'd200; tick();
        check("call1", ifc.prog_ctr, 200);
        tick();
        ifc.call = 1'b1; ifc.target = 10'd300; tick();
        check("call2", ifc.prog_ctr, 300);
        ifc.ret = 1'b1; tick();
        check("ret1", ifc.prog_ctr, RAS ? 202 : 301);
        ifc.ret = 1'b1; tick();
        check("ret2", ifc.prog_ctr, RAS ? 21 : 302);
        check("ret_no_err", ifc.stack_err, 0);

        ifc.branch_abs = 1'b1; ifc.target = 10'd9; tick();
        ifc.halt = 1'b1; tick();
        check("halt_done", ifc.done, 1);
        check("halt_pc", ifc.prog_ctr, 9);
        ifc.start = 1'b1; tick();
        check("prog1_num", ifc.prog_num, 1);
        check("prog1_pc", ifc.prog_ctr, 256);
        ifc.halt = 1'b1; tick();
        ifc.start = 1'b1; tick();
        check("prog2_num", ifc.prog_num, 2);
        check("prog2_pc", ifc.prog_ctr, 512);
        ifc.halt = 1'b1; tick();
        ifc.start = 1'b1; tick();
        check("last_prog_stays_halt", ifc.done, 1);

        rst = 1'b1; tick();
        ifc.start = 1'b1; tick();
        for (int k = 1; k <= 5; k++) begin
            ifc.call = 1'b1; ifc.target = L'(k * 10); tick();
            if (k == 4) check("four_calls_no_err", ifc.stack_err, 0);
        end
        check("overflow_err", ifc.stack_err, RAS ? 1 : 0);
        check("overflow_jump", ifc.prog_ctr, 50);

        rst = 1'b1; tick();
        ifc.start = 1'b1; tick();
        ifc.ret = 1'b1; tick();
        check("underflow_pc", ifc.prog_ctr, 1);
        check("underflow_err", ifc.stack_err, RAS ? 1 : 0);

        ifc.branch_abs = 1'b1; ifc.target = 10'd1023; tick();
        check("pc_max", ifc.prog_ctr, 1023);
        tick();
        check("pc_wrap", ifc.prog_ctr, 0);

        ifc.call = 1'b1; ifc.target = 10'd100; tick();
        ifc.call = 1'b1; ifc.target = 10'd200; tick();
        rst = 1'b1; ifc.call = 1'b1; ifc.target = 10'd300; tick();
        check("midcall_reset_pc", ifc.prog_ctr, 0);
        check("midcall_reset_idle", ifc.running, 0);
        check("midcall_reset_err", ifc.stack_err, 0);
        ifc.start = 1'b1; tick();
        ifc.ret = 1'b1; tick();
        check("stack_discarded", ifc.stack_err, RAS ? 1 : 0);

        for (int i = 0; i < 1500; i++) begin
            rst            = ($urandom_range(0, 63) == 0);
            ifc.start      = ($urandom_range(0, 7) == 0);
            ifc.halt       = ($urandom_range(0, 31) == 0);
            ifc.ret        = ($urandom_range(0, 5) == 0);
            ifc.call       = ($urandom_range(0, 5) == 0);
            ifc.branch_abs = ($urandom_range(0, 5) == 0);
            ifc.branch_rel = ($urandom_range(0, 5) == 0);
            ifc.cond       = 1'($urandom_range(0, 1));
            ifc.alu_flag   = 1'($urandom_range(0, 1));
            ifc.target     = L'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/prog_seq.md
# prog_seq

Parametrised program sequencer replacing the single-program PC: holds the fetch address for instruction memory and advances it by increment, absolute or PC-relative branch (optionally conditional on the ALU flag), or subroutine call/return through a small return-address stack. It sequences up to NPROG programs: each Start launches the next program at its fixed base address, and each Halt parks the sequencer. It sits between the decoder/ALU and the instruction ROM address port.

## Interface
- L, 10, PC width in bits
- NPROG, 3, number of programs; program k starts at k*PROG_STRIDE truncated to L bits
- PROG_STRIDE, 256, address spacing between program bases
- DEPTH, 4, return-address stack entries (power of 2, ≥2)

- Clk  in  1  clock; all state changes on posedge only
- Reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- Start  in  1  launch next program (honoured in IDLE/HALT only)
- Halt  in  1  current instruction is halt
- BranchAbs  in  1  jump to Target
- BranchRel  in  1  jump to ProgCtr + signed Target
- Cond  in  1  1: branch/call taken only if ALU_flag=1; 0: unconditional
- ALU_flag  in  1  condition flag from ALU
- Call  in  1  push ProgCtr+1, jump to Target
- Ret  in  1  pop return address into ProgCtr
- Target  in  L  absolute address or two's-complement offset
- ProgCtr  out  L  program counter register
- ProgNum  out  max(1,$clog2(NPROG))  index of current program
- Running  out  1  state==RUN
- Done  out  1  state==HALT
- StackErr  out  1  sticky overflow/underflow flag

## Operation
- States: IDLE, RUN, HALT. Reset → IDLE, ProgCtr=0, ProgNum=0, stack empty, StackErr=0.
- IDLE: ProgCtr holds. Start → RUN, ProgCtr=base(ProgNum).
- HALT: ProgCtr holds. Start with ProgNum<NPROG-1 → ProgNum+1, ProgCtr=base(ProgNum+1), stack emptied, RUN. Start with ProgNum=NPROG-1 → stay HALT.
- RUN, highest priority first (one action per cycle):
  - Halt → HALT, ProgCtr holds.
  - Ret: stack non-empty → ProgCtr=top, pop. Empty → StackErr=1, ProgCtr+1.
  - Call (taken if Cond=0 or ALU_flag=1): push ProgCtr+1, ProgCtr=Target. Full → no push, StackErr=1, jump still taken. Not taken → ProgCtr+1.
  - BranchAbs (same condition rule) → ProgCtr=Target, else ProgCtr+1.
  - BranchRel (same rule) → ProgCtr=ProgCtr+sign-extended Target.
  - none → ProgCtr+1.
- Start ignored in RUN. Halt/Ret/Call/Branch*/Cond ignored outside RUN.
- All address arithmetic modulo 2^L: increment from 2^L-1 wraps to 0; relative branch wraps in both directions; pushed return address ProgCtr+1 wraps likewise.
- Stack: LIFO of DEPTH entries of L bits; occupancy counter 0..DEPTH. StackErr clears only on Reset.

## Timing
- Single-cycle: controls sampled at posedge N; new ProgCtr, ProgNum, state and flags visible after posedge N (registered outputs, no combinational input→output path).
- Running/Done decode registered state; Running rises on the edge consuming Start.
- Call followed immediately by Ret on the next cycle returns to call-site+1; back-to-back push/pop need no bubbles.
- Reset mid-program wins over every other input in the same cycle; stack contents discarded.
- Same-cycle Start+Reset → IDLE (Reset wins).

## Configuration
- PROG_SEQ_RAS_EN defined: return-address stack and StackErr logic present as above.
- Not defined: no stack storage; Call behaves exactly as BranchAbs (no push); Ret treated as no control (ProgCtr+1); StackErr tied 0.

## Test plan
- Reset, Start, 5 idle cycles → ProgCtr 0,1,2,3,4,5; Running=1; ProgNum=0.
- At ProgCtr=7, BranchRel Target=10'h3FC (−4), Cond=0 → ProgCtr=3; at ProgCtr=3, BranchAbs Cond=1 ALU_flag=0 Target=100 → ProgCtr=4.
- At ProgCtr=20 Call Target=200; at 201 Call Target=300; Ret at 300 → 202; Ret at 202 → 21; StackErr=0.
- DEPTH=4: five nested Calls → StackErr=1 after fifth, fifth jump taken; Ret on empty stack after reset+Start → StackErr=1, ProgCtr increments.
- Halt at ProgCtr=9 → Done=1, ProgCtr holds 9; Start → ProgNum=1, ProgCtr=256; Halt, Start → ProgNum=2, ProgCtr=512; Halt, Start → stays HALT.
- ProgCtr=1023 no control → 0; Reset asserted mid-Call chain → ProgCtr=0, IDLE, stack empty, StackErr=0.
